// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch buffer entry layout, NOP/JAL encodings and the reset PC default.
// Build option: FETCH_JAL_PREDICT_EN enables the JAL target helper's use in fetch_stage.
package fetch_stage_pkg;

    typedef logic [31:0] instruction_t;

    localparam instruction_t NOP_INSTR        = 32'h0000_0013;
    localparam logic [6:0]   OPCODE_JAL       = 7'b1101111;
    localparam logic [31:0]  RESET_PC_DEFAULT = 32'h0000_0000;

    // Width of the count of responses still owed by memory for flushed requests.
    localparam int DROP_W = 8;

    typedef struct packed {
        instruction_t instr;
        logic [31:0]  pc;
    } fetch_entry_t;

    // pc + sign-extended J-type immediate of a JAL word.
    function automatic logic [31:0] jal_target(input logic [31:0] pc, input instruction_t i);
        logic [31:0] imm;
        imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        return pc + imm;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem request/response channels, redirect input, decode handshake.
// master = fetch stage side, slave = environment (memory, execute, decode) side.
// No logic; carries signals only.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         id_ready;
    logic         id_valid;
    instruction_t instruction;
    logic [31:0]  pc_out;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, instruction, pc_out,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, instruction, pc_out,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: synchronous FIFO of fetch_entry_t with push/pop/clear, full/empty/count.
// Latency: pushed entry visible at head the cycle after push; head is a registered read.
// Backpressure: push while full is taken only with a simultaneous pop; clear beats push/pop.
// Ports: clk, reset (async high), clear, push/push_dat, pop, head_dat, full, empty, count.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  fetch_entry_t       push_dat,
    input  logic               pop,
    output fetch_entry_t       head_dat,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] rd_q, rd_d, wr_q, wr_d;
    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic           push_ok, pop_ok;

    always_comb begin
        count    = wr_q - rd_q;
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
        head_dat = mem_q[rd_q[PTR_W-1:0]];
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
    end

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        mem_d = mem_q;
        if (clear) begin
            rd_d = '0;
            wr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q[PTR_W-1:0]] = push_dat;
                wr_d = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
            wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues imem word requests, buffers {instr, pc} for decode.
// Latency: request fire at N, response at N+L -> id_valid at N+L+1 (registered buffer).
// Backpressure: requests only issue with a reserved buffer slot; decode stall holds the head.
// Ports: clk, reset (async high), bus (fetch_stage_if.master).
// Build option: FETCH_JAL_PREDICT_EN redirects fetch to JAL targets as words are buffered.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pc_last_q, pc_last_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              buf_push, buf_pop, buf_clear, buf_full, buf_empty;
    fetch_entry_t      buf_in, buf_head;
    logic [CNT_W-1:0]  buf_count;

    logic              tag_push, tag_pop, tag_clear, tag_full, tag_empty;
    fetch_entry_t      tag_in, tag_head;
    logic [CNT_W-1:0]  tag_count;

    logic              rsp_keep, rsp_drop, jal_hit, credit_ok, req_fire;
    logic [CNT_W:0]    inflight;

    assign rsp_drop = bus.imem_rsp_valid && (drop_q != '0);
    assign rsp_keep = bus.imem_rsp_valid && (drop_q == '0);

`ifdef FETCH_JAL_PREDICT_EN
    assign jal_hit = rsp_keep && !bus.redirect_valid && (bus.imem_rsp_data[6:0] == OPCODE_JAL);
`else
    assign jal_hit = 1'b0;
`endif

    // Outstanding requests already own a buffer slot, so they count against capacity.
    assign inflight  = {1'b0, out_q} + {1'b0, buf_count};
    assign credit_ok = inflight < (CNT_W+1)'(FIFO_DEPTH);

    assign bus.imem_req_valid = !reset && !bus.redirect_valid && !jal_hit && credit_ok;
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // Tag queue only holds PCs of live requests: a flush clears it, so responses
    // owed for flushed requests are absorbed by drop_q without touching it.
    assign tag_push  = req_fire;
    assign tag_in    = '{instr: '0, pc: pc_q};
    assign tag_pop   = rsp_keep;
    assign tag_clear = bus.redirect_valid || jal_hit;

    assign buf_push  = rsp_keep && !bus.redirect_valid;
    assign buf_in    = '{instr: bus.imem_rsp_data, pc: tag_head.pc};
    assign buf_pop   = !buf_empty && bus.id_ready;
    assign buf_clear = bus.redirect_valid;

    assign bus.id_valid    = !buf_empty;
    assign bus.instruction = buf_empty ? NOP_INSTR : buf_head.instr;
    assign bus.pc_out      = buf_empty ? pc_last_q : buf_head.pc;

    always_comb begin
        pc_d      = pc_q;
        out_d     = out_q + CNT_W'(req_fire) - CNT_W'(rsp_keep);
        drop_d    = drop_q - DROP_W'(rsp_drop);
        pc_last_d = buf_empty ? pc_last_q : buf_head.pc;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (bus.redirect_valid) begin
            // Every live request becomes a drop; a response arriving now is one of
            // those (or of the earlier drops) and is consumed this cycle.
            pc_d   = {bus.redirect_pc[31:2], 2'b00};
            out_d  = '0;
            drop_d = drop_q + DROP_W'(out_q) - DROP_W'(bus.imem_rsp_valid);
        end else if (jal_hit) begin
            // The JAL itself is kept; only the requests younger than it are flushed.
            pc_d   = jal_target(tag_head.pc, bus.imem_rsp_data);
            out_d  = '0;
            drop_d = DROP_W'(out_q) - DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            pc_last_q <= '0;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            pc_last_q <= pc_last_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end

    fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (buf_clear),
        .push     (buf_push),
        .push_dat (buf_in),
        .pop      (buf_pop),
        .head_dat (buf_head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    fetch_buffer #(.DEPTH(FIFO_DEPTH)) u_tag (
        .clk      (clk),
        .reset    (reset),
        .clear    (tag_clear),
        .push     (tag_push),
        .push_dat (tag_in),
        .pop      (tag_pop),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // A non-dropped response must have a matching request tag.
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (reset)
        rsp_keep |-> !tag_empty);
    a_tag_tracks_out: assert property (@(posedge clk) disable iff (reset)
        tag_count == out_q);
    a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (buf_push && !buf_pop) |-> !buf_full);
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (tag_push && !tag_pop) |-> !tag_full);
    a_drop_no_wrap: assert property (@(posedge clk) disable iff (reset)
        !(&drop_q));
    a_tag_no_instr: assert property (@(posedge clk) disable iff (reset)
        tag_empty || (tag_head.instr == '0));

endmodule
